// File: rtl/id_ex_shift_stage_pkg.sv
// Shared definitions for the ID/EX shift stage: default widths and field encodings.
package id_ex_shift_stage_pkg;

   localparam int DW   = 16;  // datapath width
   localparam int AW   = 4;   // shift-amount width, log2(DW)
   localparam int RIDX = 3;   // register index width

   // Shift-amount source select
   typedef enum logic {
      AMT_IMM = 1'b0,
      AMT_REG = 1'b1
   } amt_src_e;

   // Shifter Shft_Rot encoding
   typedef enum logic {
      SR_ROT   = 1'b0,
      SR_SHIFT = 1'b1
   } shft_rot_e;

   // Forward-hit bit positions inside {memwb_used, exmem_used}
   localparam int HIT_EXMEM = 0;
   localparam int HIT_MEMWB = 1;

endpackage

// File: rtl/id_ex_shift_stage_if.sv
// Decode-side fields, producer write-back ports and EX-side outputs of the ID/EX shift stage.
interface id_ex_shift_stage_if
   import id_ex_shift_stage_pkg::*;
#(
   parameter int DW   = id_ex_shift_stage_pkg::DW,
   parameter int AW   = id_ex_shift_stage_pkg::AW,
   parameter int RIDX = id_ex_shift_stage_pkg::RIDX
) ();

   // Decode side
   logic            id_valid;
   logic [DW-1:0]   id_rs_data;
   logic [RIDX-1:0] id_rs_idx;
   logic [DW-1:0]   id_rt_data;
   logic [RIDX-1:0] id_rt_idx;
   logic [AW-1:0]   id_imm;
   logic            id_amt_src;
   logic            id_shft_rot;
   logic            id_wr_en;
   logic [RIDX-1:0] id_wr_idx;

   // Producers further down the pipe
   logic            exmem_wr_en;
   logic [RIDX-1:0] exmem_wr_idx;
   logic [DW-1:0]   exmem_wr_data;
   logic            memwb_wr_en;
   logic [RIDX-1:0] memwb_wr_idx;
   logic [DW-1:0]   memwb_wr_data;

   // Execute side
   logic            ex_valid;
   logic [DW-1:0]   ex_in;
   logic [AW-1:0]   ex_shamt;
   logic            ex_shft_rot;
   logic            ex_wr_en;
   logic [RIDX-1:0] ex_wr_idx;
   logic [1:0]      ex_fwd_hit;

   modport master (
      output id_valid, id_rs_data, id_rs_idx, id_rt_data, id_rt_idx, id_imm,
             id_amt_src, id_shft_rot, id_wr_en, id_wr_idx,
             exmem_wr_en, exmem_wr_idx, exmem_wr_data,
             memwb_wr_en, memwb_wr_idx, memwb_wr_data,
      input  ex_valid, ex_in, ex_shamt, ex_shft_rot, ex_wr_en, ex_wr_idx, ex_fwd_hit
   );

   modport slave (
      input  id_valid, id_rs_data, id_rs_idx, id_rt_data, id_rt_idx, id_imm,
             id_amt_src, id_shft_rot, id_wr_en, id_wr_idx,
             exmem_wr_en, exmem_wr_idx, exmem_wr_data,
             memwb_wr_en, memwb_wr_idx, memwb_wr_data,
      output ex_valid, ex_in, ex_shamt, ex_shft_rot, ex_wr_en, ex_wr_idx, ex_fwd_hit
   );

endinterface

// File: rtl/id_ex_shift_stage_fwd_mux.sv
// Operand bypass: picks EX/MEM, then MEM/WB, then the captured register-file value.
module id_ex_shift_stage_fwd_mux
   import id_ex_shift_stage_pkg::*;
#(
   parameter int DW   = id_ex_shift_stage_pkg::DW,
   parameter int RIDX = id_ex_shift_stage_pkg::RIDX
) (
   input  logic [RIDX-1:0] idx_i,
   input  logic [DW-1:0]   cap_data_i,
   input  logic            exmem_wr_en_i,
   input  logic [RIDX-1:0] exmem_wr_idx_i,
   input  logic [DW-1:0]   exmem_wr_data_i,
   input  logic            memwb_wr_en_i,
   input  logic [RIDX-1:0] memwb_wr_idx_i,
   input  logic [DW-1:0]   memwb_wr_data_i,
   output logic [DW-1:0]   data_o,
   output logic [1:0]      hit_o
);

   // Youngest producer wins; no hardwired-zero register, so index 0 forwards too
   always_comb begin
      data_o = cap_data_i;
      hit_o  = 2'b00;
      if (exmem_wr_en_i && (exmem_wr_idx_i == idx_i)) begin
         data_o           = exmem_wr_data_i;
         hit_o[HIT_EXMEM] = 1'b1;
      end else if (memwb_wr_en_i && (memwb_wr_idx_i == idx_i)) begin
         data_o           = memwb_wr_data_i;
         hit_o[HIT_MEMWB] = 1'b1;
      end
   end

endmodule

// File: rtl/id_ex_shift_stage.sv
// ID/EX pipeline register feeding the right shift/rotate unit, with EX-side operand bypass.
module id_ex_shift_stage
   import id_ex_shift_stage_pkg::*;
#(
   parameter int DW   = id_ex_shift_stage_pkg::DW,
   parameter int AW   = id_ex_shift_stage_pkg::AW,
   parameter int RIDX = id_ex_shift_stage_pkg::RIDX
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   id_ex_shift_stage_if.slave bus
);

   logic            valid_q,    valid_d;
   logic            wr_en_q,    wr_en_d;
   logic [RIDX-1:0] wr_idx_q;
   logic [DW-1:0]   rs_data_q;
   logic [RIDX-1:0] rs_idx_q;
   logic [DW-1:0]   rt_data_q;
   logic [RIDX-1:0] rt_idx_q;
   logic [AW-1:0]   imm_q;
   logic            amt_src_q;
   logic            shft_rot_q;

   logic            en;
   logic [DW-1:0]   rs_fwd, rt_fwd;
   logic [1:0]      rs_hit, rt_hit;
   logic            unused_rt_hi;

   // Flush overrides stall; a stall alone freezes every register
   assign en = ~stall_i | flush_i;

   // Control next-state: flush inserts a bubble, a load qualifies write-enable by valid
   always_comb begin
      valid_d = bus.id_valid;
      wr_en_d = bus.id_wr_en & bus.id_valid;
      if (flush_i) begin
         valid_d = 1'b0;
         wr_en_d = 1'b0;
      end
   end

   // Control flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         wr_en_q <= 1'b0;
      end else if (en) begin
         valid_q <= valid_d;
         wr_en_q <= wr_en_d;
      end
   end

   // Payload flops: loaded only on a real load, held through stalls and flushes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_idx_q   <= '0;
         rs_data_q  <= '0;
         rs_idx_q   <= '0;
         rt_data_q  <= '0;
         rt_idx_q   <= '0;
         imm_q      <= '0;
         amt_src_q  <= AMT_IMM;
         shft_rot_q <= SR_ROT;
      end else if (!flush_i && !stall_i) begin
         wr_idx_q   <= bus.id_wr_idx;
         rs_data_q  <= bus.id_rs_data;
         rs_idx_q   <= bus.id_rs_idx;
         rt_data_q  <= bus.id_rt_data;
         rt_idx_q   <= bus.id_rt_idx;
         imm_q      <= bus.id_imm;
         amt_src_q  <= bus.id_amt_src;
         shft_rot_q <= bus.id_shft_rot;
      end
   end

   id_ex_shift_stage_fwd_mux #(.DW(DW), .RIDX(RIDX)) u_fwd_rs (
      .idx_i           (rs_idx_q),
      .cap_data_i      (rs_data_q),
      .exmem_wr_en_i   (bus.exmem_wr_en),
      .exmem_wr_idx_i  (bus.exmem_wr_idx),
      .exmem_wr_data_i (bus.exmem_wr_data),
      .memwb_wr_en_i   (bus.memwb_wr_en),
      .memwb_wr_idx_i  (bus.memwb_wr_idx),
      .memwb_wr_data_i (bus.memwb_wr_data),
      .data_o          (rs_fwd),
      .hit_o           (rs_hit)
   );

   id_ex_shift_stage_fwd_mux #(.DW(DW), .RIDX(RIDX)) u_fwd_rt (
      .idx_i           (rt_idx_q),
      .cap_data_i      (rt_data_q),
      .exmem_wr_en_i   (bus.exmem_wr_en),
      .exmem_wr_idx_i  (bus.exmem_wr_idx),
      .exmem_wr_data_i (bus.exmem_wr_data),
      .memwb_wr_en_i   (bus.memwb_wr_en),
      .memwb_wr_idx_i  (bus.memwb_wr_idx),
      .memwb_wr_data_i (bus.memwb_wr_data),
      .data_o          (rt_fwd),
      .hit_o           (rt_hit)
   );

   // Only the low AW bits of a register amount reach the shifter, so 16 wraps to 0
   assign unused_rt_hi = ^rt_fwd[DW-1:AW];

   // EX-side outputs; hit reporting is suppressed for bubbles, data forwarding is not
   always_comb begin
      bus.ex_valid    = valid_q;
      bus.ex_wr_en    = wr_en_q & valid_q;
      bus.ex_wr_idx   = wr_idx_q;
      bus.ex_shft_rot = shft_rot_q;
      bus.ex_in       = rs_fwd;
      bus.ex_shamt    = (amt_src_q == AMT_REG) ? rt_fwd[AW-1:0] : imm_q;
      bus.ex_fwd_hit  = 2'b00;
      if (valid_q) begin
         bus.ex_fwd_hit = rs_hit | ((amt_src_q == AMT_REG) ? rt_hit : 2'b00);
      end
   end

endmodule

// File: tb/tb_id_ex_shift_stage.sv
module tb_id_ex_shift_stage;

   logic clk = 1'b0;
   logic rst;
   logic stall;
   logic flush;

   id_ex_shift_stage_if bus ();

   id_ex_shift_stage dut (
      .clk     (clk),
      .rst     (rst),
      .stall_i (stall),
      .flush_i (flush),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid;
      logic        wr_en;
      logic [2:0]  wr_idx;
      logic [15:0] rs_data;
      logic [2:0]  rs_idx;
      logic [15:0] rt_data;
      logic [2:0]  rt_idx;
      logic [3:0]  imm;
      logic        amt_src;
      logic        shft_rot;
   } st_t;

   st_t m;
   st_t sbq[$];
   int  n_checks = 0;
   int  n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference bypass for one index: returns data and {memwb,exmem} hit
   function automatic logic [17:0] ref_fwd(input logic [2:0] idx, input logic [15:0] cap);
      if (bus.exmem_wr_en && bus.exmem_wr_idx == idx) return {2'b01, bus.exmem_wr_data};
      if (bus.memwb_wr_en && bus.memwb_wr_idx == idx) return {2'b10, bus.memwb_wr_data};
      return {2'b00, cap};
   endfunction

   task automatic check_state(input string tag, input st_t s);
      logic [17:0] frs, frt;
      logic [3:0]  esh;
      logic [1:0]  ehit;
      frs  = ref_fwd(s.rs_idx, s.rs_data);
      frt  = ref_fwd(s.rt_idx, s.rt_data);
      esh  = s.amt_src ? frt[3:0] : s.imm;
      ehit = s.valid ? (frs[17:16] | (s.amt_src ? frt[17:16] : 2'b00)) : 2'b00;
      chk({tag, ".valid"},  32'(bus.ex_valid),    32'(s.valid));
      chk({tag, ".wr_en"},  32'(bus.ex_wr_en),    32'(s.valid & s.wr_en));
      chk({tag, ".wr_idx"}, 32'(bus.ex_wr_idx),   32'(s.wr_idx));
      chk({tag, ".sr"},     32'(bus.ex_shft_rot), 32'(s.shft_rot));
      chk({tag, ".in"},     32'(bus.ex_in),       32'(frs[15:0]));
      chk({tag, ".shamt"},  32'(bus.ex_shamt),    32'(esh));
      chk({tag, ".hit"},    32'(bus.ex_fwd_hit),  32'(ehit));
   endtask

   task automatic set_id(input logic v, input logic [2:0] rsi, input logic [15:0] rsd,
                         input logic [2:0] rti, input logic [15:0] rtd, input logic [3:0] imm,
                         input logic asrc, input logic sr, input logic we, input logic [2:0] wi);
      bus.id_valid    = v;
      bus.id_rs_idx   = rsi;
      bus.id_rs_data  = rsd;
      bus.id_rt_idx   = rti;
      bus.id_rt_data  = rtd;
      bus.id_imm      = imm;
      bus.id_amt_src  = asrc;
      bus.id_shft_rot = sr;
      bus.id_wr_en    = we;
      bus.id_wr_idx   = wi;
   endtask

   task automatic set_prod(input logic ee, input logic [2:0] ei, input logic [15:0] ed,
                           input logic me, input logic [2:0] mi, input logic [15:0] md);
      bus.exmem_wr_en   = ee;
      bus.exmem_wr_idx  = ei;
      bus.exmem_wr_data = ed;
      bus.memwb_wr_en   = me;
      bus.memwb_wr_idx  = mi;
      bus.memwb_wr_data = md;
   endtask

   // Predict the register contents after the next edge, queue it, then compare once it lands
   task automatic step(input string tag);
      st_t nx;
      st_t got;
      nx = m;
      if (rst) begin
         nx = '0;
      end else if (flush) begin
         nx.valid = 1'b0;
         nx.wr_en = 1'b0;
      end else if (!stall) begin
         nx.valid    = bus.id_valid;
         nx.wr_en    = bus.id_wr_en & bus.id_valid;
         nx.wr_idx   = bus.id_wr_idx;
         nx.rs_data  = bus.id_rs_data;
         nx.rs_idx   = bus.id_rs_idx;
         nx.rt_data  = bus.id_rt_data;
         nx.rt_idx   = bus.id_rt_idx;
         nx.imm      = bus.id_imm;
         nx.amt_src  = bus.id_amt_src;
         nx.shft_rot = bus.id_shft_rot;
      end
      sbq.push_back(nx);
      m = nx;
      @(posedge clk);
      #1;
      got = sbq.pop_front();
      check_state(tag, got);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      set_prod(0, 0, 0, 0, 0, 0);
      m = '0;
      #2;
      check_state("reset", m);
      step("reset_edge");
      rst = 1'b0;

      // 1: first load after reset
      set_id(1, 3'd1, 16'hA5A5, 3'd0, 16'h0000, 4'd3, 1'b0, 1'b1, 1'b1, 3'd4);
      step("load1");
      chk("load1_in_lit", 32'(bus.ex_in), 32'h0000A5A5);
      chk("load1_sh_lit", 32'(bus.ex_shamt), 32'd3);

      // Reset raised mid-stream, while stall and flush are also high
      stall = 1'b1; flush = 1'b1;
      rst = 1'b1;
      #2;
      m = '0;
      check_state("rst_async", m);
      step("rst_hold");
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
      set_id(1, 3'd6, 16'h8001, 3'd0, 16'h0000, 4'd9, 1'b0, 1'b0, 1'b1, 3'd2);
      step("rst_release_load");

      // 2: operand forwarding priority
      set_id(1, 3'd2, 16'h5555, 3'd0, 16'h0000, 4'd1, 1'b0, 1'b1, 1'b1, 3'd3);
      set_prod(1, 3'd2, 16'h1234, 1, 3'd2, 16'hFFFF);
      step("fwd_both");
      chk("fwd_both_lit", 32'({bus.ex_fwd_hit, bus.ex_in}), 32'h00011234);
      bus.exmem_wr_en = 1'b0;
      #1;
      check_state("fwd_memwb", m);
      chk("fwd_memwb_lit", 32'({bus.ex_fwd_hit, bus.ex_in}), 32'h0002FFFF);
      bus.memwb_wr_en = 1'b0;
      #1;
      check_state("fwd_none", m);

      // 3: register-sourced amount, upper bits dropped
      set_id(1, 3'd1, 16'h0F0F, 3'd5, 16'h0000, 4'd2, 1'b1, 1'b1, 1'b0, 3'd0);
      set_prod(0, 3'd0, 16'h0000, 1, 3'd5, 16'h0017);
      step("amt_reg");
      chk("amt_reg_lit", 32'({bus.ex_fwd_hit, bus.ex_shamt}), 32'h00000027);
      set_prod(1, 3'd5, 16'h0010, 1, 3'd5, 16'h0017);
      #1;
      check_state("amt_wrap", m);
      chk("amt_wrap_lit", 32'(bus.ex_shamt), 32'd0);

      // 4: stall holds registered fields; forwarding still tracks producers
      set_prod(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_id(1, 3'($urandom), 16'($urandom), 3'($urandom), 16'($urandom), 4'($urandom),
                1'($urandom), 1'($urandom), 1, 3'($urandom));
         step("stall");
      end
      set_prod(1, 3'd1, 16'hBEEF, 0, 3'd0, 16'h0000);
      #1;
      check_state("stall_fwd", m);
      chk("stall_fwd_lit", 32'(bus.ex_in), 32'h0000BEEF);

      // 5: flush beats stall
      flush = 1'b1;
      set_id(1, 3'd1, 16'h1111, 3'd5, 16'h0003, 4'd4, 1'b1, 1'b1, 1'b1, 3'd7);
      step("flush");
      chk("flush_lit", 32'({bus.ex_valid, bus.ex_wr_en, bus.ex_fwd_hit}), 32'd0);
      stall = 1'b0; flush = 1'b0;

      // 6: back-to-back loads
      set_prod(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000);
      begin
         logic [3:0] imms [4] = '{4'd0, 4'd5, 4'd15, 4'd8};
         for (int i = 0; i < 4; i++) begin
            set_id(1, 3'(i), 16'h1000 + 16'(i), 3'd0, 16'h0000, imms[i], 1'b0, 1'b1, 1'b1, 3'(i));
            step("b2b");
            chk("b2b_shamt_lit", 32'(bus.ex_shamt), 32'(imms[i]));
            chk("b2b_valid_lit", 32'(bus.ex_valid), 32'd1);
         end
      end

      // Mixed random traffic
      for (int i = 0; i < 40; i++) begin
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 5) == 0);
         set_id(1'($urandom), 3'($urandom), 16'($urandom), 3'($urandom), 16'($urandom),
                4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
         set_prod(1'($urandom), 3'($urandom), 16'($urandom), 1'($urandom), 3'($urandom), 16'($urandom));
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
